// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults, write-port tuple type and the write-first
//                bypass helper used by both read ports of regfile_mp.
//  Contents    : DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_ZERO_REG
//                MAX_WIDTH / MAX_AW  - widest data / address the helper takes
//                wr_port_t           - (enable, address, data) of a write port
//                bypass_read()       - bypassed read value for one read port
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_DEPTH    = 32;
    localparam int DEFAULT_ZERO_REG = 1;

    // The helper works on widened operands so a single function serves every
    // instance regardless of WIDTH/DEPTH; callers size-cast in and out.
    localparam int MAX_WIDTH = 128;
    localparam int MAX_AW    = 16;

    typedef struct packed {
        logic                 en;
        logic [MAX_AW-1:0]    addr;
        logic [MAX_WIDTH-1:0] data;
    } wr_port_t;

    // Write-first read: hardwired zero, then port 1, then port 0, then storage.
    // Port 1 is checked first because it also wins a same-address write.
    function automatic logic [MAX_WIDTH-1:0] bypass_read(
        input logic                 zero_en,
        input logic [MAX_AW-1:0]    addr,
        input wr_port_t             wp0,
        input wr_port_t             wp1,
        input logic [MAX_WIDTH-1:0] stored
    );
        logic [MAX_WIDTH-1:0] result;
        if (zero_en && (addr == '0)) begin
            result = '0;
        end else if (wp1.en && (wp1.addr == addr)) begin
            result = wp1.data;
        end else if (wp0.en && (wp0.addr == addr)) begin
            result = wp0.data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Read / write-back / issue bundle of the multi-port register
//                file. The core side drives it through 'master', the register
//                file sits on 'slave'.
//  Signals     : iwReadReg1/2   -> read addresses
//                owReadData1/2  <- combinational read data
//                owBusy1/2      <- pending-write flags of the read addresses
//                iwWriteEnable0/1, iwWriteReg0/1, iwWriteData0/1 -> write-back
//                iwIssueEnable, iwIssueReg -> destination being issued
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    iwReadReg1;
    logic [AW-1:0]    iwReadReg2;
    logic [WIDTH-1:0] owReadData1;
    logic [WIDTH-1:0] owReadData2;
    logic             owBusy1;
    logic             owBusy2;
    logic             iwWriteEnable0;
    logic             iwWriteEnable1;
    logic [AW-1:0]    iwWriteReg0;
    logic [AW-1:0]    iwWriteReg1;
    logic [WIDTH-1:0] iwWriteData0;
    logic [WIDTH-1:0] iwWriteData1;
    logic             iwIssueEnable;
    logic [AW-1:0]    iwIssueReg;

    modport master (
        output iwReadReg1, iwReadReg2,
        input  owReadData1, owReadData2, owBusy1, owBusy2,
        output iwWriteEnable0, iwWriteEnable1, iwWriteReg0, iwWriteReg1,
        output iwWriteData0, iwWriteData1, iwIssueEnable, iwIssueReg
    );

    modport slave (
        input  iwReadReg1, iwReadReg2,
        output owReadData1, owReadData2, owBusy1, owBusy2,
        input  iwWriteEnable0, iwWriteEnable1, iwWriteReg0, iwWriteReg1,
        input  iwWriteData0, iwWriteData1, iwIssueEnable, iwIssueReg
    );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending-write flags. Issue sets a flag one edge
//                later, write-back clears it; issue beats write-back on the
//                same register. Read-side flags are masked by a write-back in
//                the current cycle so a result arriving now is no hazard.
//  Ports       : iwClk, iwnRst            clock / async active-low reset
//                iwIssueEnable, iwIssueReg   set request
//                iwWriteEnable0/1, iwWriteReg0/1  clear requests
//                iwReadReg1/2 -> owBusy1/2   masked busy for the read ports
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  wire                       iwClk,
    input  wire                       iwnRst,
    input  wire                       iwIssueEnable,
    input  wire [$clog2(DEPTH)-1:0]   iwIssueReg,
    input  wire                       iwWriteEnable0,
    input  wire [$clog2(DEPTH)-1:0]   iwWriteReg0,
    input  wire                       iwWriteEnable1,
    input  wire [$clog2(DEPTH)-1:0]   iwWriteReg1,
    input  wire [$clog2(DEPTH)-1:0]   iwReadReg1,
    input  wire [$clog2(DEPTH)-1:0]   iwReadReg2,
    output logic                      owBusy1,
    output logic                      owBusy2
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (iwIssueEnable && (iwIssueReg == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((iwWriteEnable0 && (iwWriteReg0 == AW'(r))) ||
                         (iwWriteEnable1 && (iwWriteReg1 == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        // A hardwired zero register never has an outstanding producer.
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    logic w_wb_hit1;
    logic w_wb_hit2;

    assign w_wb_hit1 = (iwWriteEnable0 && (iwWriteReg0 == iwReadReg1)) ||
                       (iwWriteEnable1 && (iwWriteReg1 == iwReadReg1));
    assign w_wb_hit2 = (iwWriteEnable0 && (iwWriteReg0 == iwReadReg2)) ||
                       (iwWriteEnable1 && (iwWriteReg1 == iwReadReg2));

    assign owBusy1 = busy_q[iwReadReg1] & ~w_wb_hit1;
    assign owBusy2 = busy_q[iwReadReg2] & ~w_wb_hit2;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Two-write / two-read register file with write-first bypass
//                and a pending-write scoreboard. Register 0 optionally reads
//                as zero, discards writes and is never busy.
//  Ports       : iwClk   clock, rising edge
//                iwnRst  asynchronous active-low reset (clears data and busy)
//                bus     regfile_mp_if.slave - reads, write-back, issue
//  Notes       : WIDTH must not exceed regfile_pkg::MAX_WIDTH and
//                $clog2(DEPTH) must not exceed regfile_pkg::MAX_AW.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
    input  wire          iwClk,
    input  wire          iwnRst,
    regfile_mp_if.slave  bus
);

    localparam int   AW          = $clog2(DEPTH);
    localparam logic C_ZERO_EN   = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];

    // ------------------------------------------------------------------
    // Storage. Port 1 is written after port 0 so it wins on a collision.
    // ------------------------------------------------------------------
    logic w_wr0_ok;
    logic w_wr1_ok;

    assign w_wr0_ok = bus.iwWriteEnable0 && !(C_ZERO_EN && (bus.iwWriteReg0 == '0));
    assign w_wr1_ok = bus.iwWriteEnable1 && !(C_ZERO_EN && (bus.iwWriteReg1 == '0));

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (w_wr0_ok) begin
                regs_q[bus.iwWriteReg0] <= bus.iwWriteData0;
            end
            if (w_wr1_ok) begin
                regs_q[bus.iwWriteReg1] <= bus.iwWriteData1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bypassed reads
    // ------------------------------------------------------------------
    wr_port_t w_wp0;
    wr_port_t w_wp1;

    always_comb begin
        w_wp0      = '0;
        w_wp0.en   = bus.iwWriteEnable0;
        w_wp0.addr = MAX_AW'(bus.iwWriteReg0);
        w_wp0.data = MAX_WIDTH'(bus.iwWriteData0);
        w_wp1      = '0;
        w_wp1.en   = bus.iwWriteEnable1;
        w_wp1.addr = MAX_AW'(bus.iwWriteReg1);
        w_wp1.data = MAX_WIDTH'(bus.iwWriteData1);
    end

    // Held reset forces zero so the bypass cannot leak write data.
    assign bus.owReadData1 = iwnRst
        ? WIDTH'(bypass_read(C_ZERO_EN, MAX_AW'(bus.iwReadReg1), w_wp0, w_wp1,
                             MAX_WIDTH'(regs_q[bus.iwReadReg1])))
        : '0;
    assign bus.owReadData2 = iwnRst
        ? WIDTH'(bypass_read(C_ZERO_EN, MAX_AW'(bus.iwReadReg2), w_wp0, w_wp1,
                             MAX_WIDTH'(regs_q[bus.iwReadReg2])))
        : '0;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .iwClk          (iwClk),
        .iwnRst         (iwnRst),
        .iwIssueEnable  (bus.iwIssueEnable),
        .iwIssueReg     (AW'(bus.iwIssueReg)),
        .iwWriteEnable0 (bus.iwWriteEnable0),
        .iwWriteReg0    (bus.iwWriteReg0),
        .iwWriteEnable1 (bus.iwWriteEnable1),
        .iwWriteReg1    (bus.iwWriteReg1),
        .iwReadReg1     (bus.iwReadReg1),
        .iwReadReg2     (bus.iwReadReg2),
        .owBusy1        (bus.owBusy1),
        .owBusy2        (bus.owBusy2)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed checks on a 32x32 instance (zero register on and
//                off) followed by random dual-write / dual-read / issue
//                traffic on 16x8 and 64x64 instances against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32)) ifA ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(32)) ifB ();
    regfile_mp_if #(.WIDTH(16), .DEPTH(8))  ifC ();
    regfile_mp_if #(.WIDTH(64), .DEPTH(64)) ifD ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) uA (.iwClk(clk), .iwnRst(nrst), .bus(ifA.slave));
    regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) uB (.iwClk(clk), .iwnRst(nrst), .bus(ifB.slave));
    regfile_mp #(.WIDTH(16), .DEPTH(8),  .ZERO_REG(1)) uC (.iwClk(clk), .iwnRst(nrst), .bus(ifC.slave));
    regfile_mp #(.WIDTH(64), .DEPTH(64), .ZERO_REG(0)) uD (.iwClk(clk), .iwnRst(nrst), .bus(ifD.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference models: stored values and outstanding-producer sets.
    logic [63:0] mC [8];
    logic [63:0] mD [64];
    bit          pC [8];
    bit          pD [64];

    // Value a read returns this cycle, straight from the read rules.
    function automatic logic [63:0] ref_read(input bit zero, input int a,
            input bit we0, input int wa0, input logic [63:0] wd0,
            input bit we1, input int wa1, input logic [63:0] wd1,
            input logic [63:0] stored);
        if (zero && a == 0)        return 64'd0;
        if (we1 && wa1 == a)       return wd1;
        if (we0 && wa0 == a)       return wd0;
        return stored;
    endfunction

    initial begin
        bit we0, we1, iss;
        int wa0, wa1, ra1, ra2, ir;
        logic [63:0] wd0, wd1;

        ifA.iwReadReg1 = '0; ifA.iwReadReg2 = '0; ifA.iwWriteEnable0 = 0; ifA.iwWriteEnable1 = 0;
        ifA.iwWriteReg0 = '0; ifA.iwWriteReg1 = '0; ifA.iwWriteData0 = '0; ifA.iwWriteData1 = '0;
        ifA.iwIssueEnable = 0; ifA.iwIssueReg = '0;
        ifB.iwReadReg1 = '0; ifB.iwReadReg2 = '0; ifB.iwWriteEnable0 = 0; ifB.iwWriteEnable1 = 0;
        ifB.iwWriteReg0 = '0; ifB.iwWriteReg1 = '0; ifB.iwWriteData0 = '0; ifB.iwWriteData1 = '0;
        ifB.iwIssueEnable = 0; ifB.iwIssueReg = '0;
        ifC.iwReadReg1 = '0; ifC.iwReadReg2 = '0; ifC.iwWriteEnable0 = 0; ifC.iwWriteEnable1 = 0;
        ifC.iwWriteReg0 = '0; ifC.iwWriteReg1 = '0; ifC.iwWriteData0 = '0; ifC.iwWriteData1 = '0;
        ifC.iwIssueEnable = 0; ifC.iwIssueReg = '0;
        ifD.iwReadReg1 = '0; ifD.iwReadReg2 = '0; ifD.iwWriteEnable0 = 0; ifD.iwWriteEnable1 = 0;
        ifD.iwWriteReg0 = '0; ifD.iwWriteReg1 = '0; ifD.iwWriteData0 = '0; ifD.iwWriteData1 = '0;
        ifD.iwIssueEnable = 0; ifD.iwIssueReg = '0;
        for (int i = 0; i < 8; i++)  begin mC[i] = '0; pC[i] = 0; end
        for (int i = 0; i < 64; i++) begin mD[i] = '0; pD[i] = 0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        ifA.iwReadReg1 = 5'd5;
        #1;
        chk("reset_state_data", 64'(ifA.owReadData1), 64'd0);
        chk("reset_state_busy", 64'(ifA.owBusy1), 64'd0);

        // ---- asynchronous reset mid-operation ----
        @(negedge clk);
        ifA.iwWriteEnable0 = 1; ifA.iwWriteReg0 = 5'd5; ifA.iwWriteData0 = 32'hDEADBEEF;
        ifA.iwIssueEnable = 1;  ifA.iwIssueReg = 5'd5;
        @(posedge clk);
        @(negedge clk);
        ifA.iwWriteEnable0 = 0; ifA.iwIssueEnable = 0;
        #1;
        chk("pre_reset_data", 64'(ifA.owReadData1), 64'hDEADBEEF);
        chk("pre_reset_busy", 64'(ifA.owBusy1), 64'd1);
        #1;
        nrst = 1'b0;
        #1;
        chk("async_reset_data", 64'(ifA.owReadData1), 64'd0);
        chk("async_reset_busy", 64'(ifA.owBusy1), 64'd0);
        ifA.iwWriteEnable0 = 1; ifA.iwWriteData0 = 32'h11111111;
        #1;
        chk("reset_no_bypass", 64'(ifA.owReadData1), 64'd0);
        @(posedge clk);
        @(negedge clk);
        ifA.iwWriteEnable0 = 0;
        nrst = 1'b1;
        #1;
        chk("post_reset_data", 64'(ifA.owReadData1), 64'd0);
        chk("post_reset_busy", 64'(ifA.owBusy1), 64'd0);

        // ---- same-cycle bypass ----
        @(negedge clk);
        ifA.iwWriteEnable0 = 1; ifA.iwWriteReg0 = 5'd3; ifA.iwWriteData0 = 32'h12345678;
        ifA.iwReadReg1 = 5'd3;
        #1;
        chk("bypass_same_cycle", 64'(ifA.owReadData1), 64'h12345678);
        @(posedge clk);
        @(negedge clk);
        ifA.iwWriteEnable0 = 0;
        #1;
        chk("bypass_stored", 64'(ifA.owReadData1), 64'h12345678);

        // ---- write conflict ----
        @(negedge clk);
        ifA.iwWriteEnable0 = 1; ifA.iwWriteReg0 = 5'd7; ifA.iwWriteData0 = 32'h1;
        ifA.iwWriteEnable1 = 1; ifA.iwWriteReg1 = 5'd7; ifA.iwWriteData1 = 32'h2;
        ifA.iwReadReg1 = 5'd7;
        #1;
        chk("conflict_bypass", 64'(ifA.owReadData1), 64'h2);
        @(posedge clk);
        @(negedge clk);
        ifA.iwWriteEnable0 = 0; ifA.iwWriteEnable1 = 0;
        #1;
        chk("conflict_stored", 64'(ifA.owReadData1), 64'h2);

        // ---- zero register on (A) and off (B) ----
        @(negedge clk);
        ifA.iwWriteEnable0 = 1; ifA.iwWriteReg0 = 5'd0; ifA.iwWriteData0 = 32'hFFFFFFFF;
        ifA.iwIssueEnable = 1;  ifA.iwIssueReg = 5'd0; ifA.iwReadReg1 = 5'd0;
        ifB.iwWriteEnable0 = 1; ifB.iwWriteReg0 = 5'd0; ifB.iwWriteData0 = 32'hFFFFFFFF;
        ifB.iwIssueEnable = 1;  ifB.iwIssueReg = 5'd0; ifB.iwReadReg1 = 5'd0;
        #1;
        chk("zero_data_c0", 64'(ifA.owReadData1), 64'd0);
        chk("zero_busy_c0", 64'(ifA.owBusy1), 64'd0);
        chk("nozero_bypass", 64'(ifB.owReadData1), 64'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        ifA.iwWriteEnable0 = 0; ifA.iwIssueEnable = 0;
        ifB.iwWriteEnable0 = 0; ifB.iwIssueEnable = 0;
        #1;
        chk("zero_data_c1", 64'(ifA.owReadData1), 64'd0);
        chk("zero_busy_c1", 64'(ifA.owBusy1), 64'd0);
        chk("nozero_stored", 64'(ifB.owReadData1), 64'hFFFFFFFF);
        chk("nozero_busy", 64'(ifB.owBusy1), 64'd1);

        // ---- scoreboard ----
        @(negedge clk);
        ifA.iwIssueEnable = 1; ifA.iwIssueReg = 5'd9; ifA.iwReadReg2 = 5'd9;
        #1;
        chk("issue_not_same_cycle", 64'(ifA.owBusy2), 64'd0);
        @(posedge clk);
        @(negedge clk);
        ifA.iwIssueEnable = 0;
        #1;
        chk("issue_busy_next", 64'(ifA.owBusy2), 64'd1);
        @(negedge clk);
        ifA.iwWriteEnable1 = 1; ifA.iwWriteReg1 = 5'd9; ifA.iwWriteData1 = 32'hAA;
        #1;
        chk("wb_masks_busy", 64'(ifA.owBusy2), 64'd0);
        chk("wb_bypass_rd2", 64'(ifA.owReadData2), 64'hAA);
        @(posedge clk);
        @(negedge clk);
        ifA.iwWriteEnable1 = 0;
        #1;
        chk("wb_busy_cleared", 64'(ifA.owBusy2), 64'd0);
        @(negedge clk);
        ifA.iwIssueEnable = 1;  ifA.iwIssueReg = 5'd9;
        ifA.iwWriteEnable1 = 1; ifA.iwWriteData1 = 32'hBB;
        @(posedge clk);
        @(negedge clk);
        ifA.iwIssueEnable = 0; ifA.iwWriteEnable1 = 0;
        #1;
        chk("issue_wins_wb", 64'(ifA.owBusy2), 64'd1);
        chk("issue_wb_data", 64'(ifA.owReadData2), 64'hBB);

        // ---- random traffic on 16x8 (zero reg) and 64x64 (no zero reg) ----
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            // C: WIDTH 16, DEPTH 8, ZERO_REG 1
            we0 = 1'($urandom); we1 = 1'($urandom); iss = 1'($urandom);
            wa0 = int'($urandom_range(0, 7)); wa1 = int'($urandom_range(0, 7));
            ir  = int'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? wa1 : int'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 3) == 0) ? wa0 : int'($urandom_range(0, 7));
            wd0 = 64'($urandom & 32'hFFFF); wd1 = 64'($urandom & 32'hFFFF);
            ifC.iwWriteEnable0 = we0; ifC.iwWriteReg0 = 3'(wa0); ifC.iwWriteData0 = 16'(wd0);
            ifC.iwWriteEnable1 = we1; ifC.iwWriteReg1 = 3'(wa1); ifC.iwWriteData1 = 16'(wd1);
            ifC.iwIssueEnable = iss;  ifC.iwIssueReg = 3'(ir);
            ifC.iwReadReg1 = 3'(ra1); ifC.iwReadReg2 = 3'(ra2);
            #1;
            chk("C_rd1", 64'(ifC.owReadData1), ref_read(1, ra1, we0, wa0, wd0, we1, wa1, wd1, mC[ra1]));
            chk("C_rd2", 64'(ifC.owReadData2), ref_read(1, ra2, we0, wa0, wd0, we1, wa1, wd1, mC[ra2]));
            chk("C_busy1", 64'(ifC.owBusy1), 64'(pC[ra1] && !((we0 && wa0 == ra1) || (we1 && wa1 == ra1))));
            chk("C_busy2", 64'(ifC.owBusy2), 64'(pC[ra2] && !((we0 && wa0 == ra2) || (we1 && wa1 == ra2))));
            if (we0 && wa0 != 0) mC[wa0] = wd0;
            if (we1 && wa1 != 0) mC[wa1] = wd1;
            if (we0) pC[wa0] = 0;
            if (we1) pC[wa1] = 0;
            if (iss && ir != 0) pC[ir] = 1;

            // D: WIDTH 64, DEPTH 64, ZERO_REG 0
            we0 = 1'($urandom); we1 = 1'($urandom); iss = 1'($urandom);
            wa0 = int'($urandom_range(0, 63)); wa1 = int'($urandom_range(0, 63));
            ir  = ($urandom_range(0, 1) == 0) ? wa0 : int'($urandom_range(0, 63));
            ra1 = ($urandom_range(0, 3) == 0) ? wa1 : int'($urandom_range(0, 63));
            ra2 = ($urandom_range(0, 3) == 0) ? ir  : int'($urandom_range(0, 63));
            wd0 = {$urandom, $urandom}; wd1 = {$urandom, $urandom};
            ifD.iwWriteEnable0 = we0; ifD.iwWriteReg0 = 6'(wa0); ifD.iwWriteData0 = wd0;
            ifD.iwWriteEnable1 = we1; ifD.iwWriteReg1 = 6'(wa1); ifD.iwWriteData1 = wd1;
            ifD.iwIssueEnable = iss;  ifD.iwIssueReg = 6'(ir);
            ifD.iwReadReg1 = 6'(ra1); ifD.iwReadReg2 = 6'(ra2);
            #1;
            chk("D_rd1", ifD.owReadData1, ref_read(0, ra1, we0, wa0, wd0, we1, wa1, wd1, mD[ra1]));
            chk("D_rd2", ifD.owReadData2, ref_read(0, ra2, we0, wa0, wd0, we1, wa1, wd1, mD[ra2]));
            chk("D_busy1", 64'(ifD.owBusy1), 64'(pD[ra1] && !((we0 && wa0 == ra1) || (we1 && wa1 == ra1))));
            chk("D_busy2", 64'(ifD.owBusy2), 64'(pD[ra2] && !((we0 && wa0 == ra2) || (we1 && wa1 == ra2))));
            if (we0) mD[wa0] = wd0;
            if (we1) mD[wa1] = wd1;
            if (we0) pD[wa0] = 0;
            if (we1) pD[wa1] = 0;
            if (iss) pD[ir] = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with same-cycle write bypass and a per-register pending-write scoreboard. It is the next-generation register file for the pipelined core: two result buses write back per cycle and two operand reads are served per cycle. Issue logic uses the busy flags to stall on read-after-write hazards. Register 0 is optionally hardwired to zero.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥ 2)
- AW, $clog2(DEPTH), register address width (derived, not overridden)
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy

Ports:
- iwClk  input  1  clock, rising edge active
- iwnRst  input  1  reset, asynchronous, active-low
- iwReadReg1, iwReadReg2  input  AW  read addresses
- owReadData1, owReadData2  output  WIDTH  read data, combinational
- owBusy1, owBusy2  output  1  pending-write flag for iwReadReg1 and iwReadReg2
- iwWriteEnable0, iwWriteEnable1  input  1  write strobes, ports 0 and 1
- iwWriteReg0, iwWriteReg1  input  AW  write addresses
- iwWriteData0, iwWriteData1  input  WIDTH  write data
- iwIssueEnable  input  1  marks iwIssueReg as pending
- iwIssueReg  input  AW  destination register of the issuing instruction

## Operation
- Storage: DEPTH × WIDTH registers plus a DEPTH-bit busy vector.
- Write: on the rising edge, each enabled port writes rRegFile[iwWriteRegN] <= iwWriteDataN.
- Write conflict: if both ports are enabled to the same address, port 1 wins.
- Zero register: when ZERO_REG=1, writes to address 0 are discarded.
- Read with bypass (write-first), evaluated per read port in priority order:
  - ZERO_REG=1 and address 0 → 0.
  - Else port 1 enabled to the same address → iwWriteData1.
  - Else port 0 enabled to the same address → iwWriteData0.
  - Else the stored value.
- Scoreboard, per register r, at the rising edge:
  - busy[r] is set if iwIssueEnable and iwIssueReg == r.
  - Otherwise busy[r] is cleared if either write port is enabled to r.
  - Issue and writeback of the same register in the same cycle leaves busy = 1, so the new producer is outstanding.
- Busy outputs: owBusyN = busy[iwReadRegN] & ~(either write port enabled to iwReadRegN this cycle). A result arriving this cycle is therefore not a hazard, which is consistent with the bypass.
- Issue this cycle does not raise owBusyN until the next cycle.
- Zero register scoreboard: when ZERO_REG=1, issue to register 0 is ignored and busy[0] stays 0.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Reset:
  - iwnRst low clears every register to 0 and every busy bit to 0, immediately and independently of the clock.
  - While iwnRst is held low, owReadDataN = 0 and owBusyN = 0. Bypass is inactive.
- Reset mid-operation: a write or issue in the cycle of the reset assertion is lost. The first edge with iwnRst high performs normal writes.
- Write latency: stored at the edge, visible through storage from that edge onward, and visible through bypass in the same cycle.
- Read latency: 0 cycles. The read path is combinational from address, write strobes and write data.
- Busy latency: set 1 cycle after issue, and cleared combinationally in the writeback cycle.
- No handshake; all inputs are sampled every cycle.

## Structure
- Package regfile_pkg:
  - default WIDTH, DEPTH and ZERO_REG constants
  - a function computing the bypassed read value from (address, two write port tuples, stored value), shared by both read ports
- Sub-module regfile_scoreboard:
  - parameters DEPTH and ZERO_REG
  - holds the busy vector and set/clear priority
  - produces the two masked busy outputs
  - instantiated once
- Data array and bypass muxes stay in regfile_mp.

## Test plan
- Reset: write 0xDEADBEEF to r5, issue r5, assert iwnRst low mid-cycle → owReadData1 (r5) = 0 and owBusy1 = 0 immediately, and after release.
- Bypass: write port 0, r3 = 0x12345678, read r3 in the same cycle → owReadData1 = 0x12345678 before the edge, and still after it with the write deasserted.
- Conflict: both ports write r7 (port 0 = 0x1, port 1 = 0x2) → same-cycle read = 0x2, stored value = 0x2.
- Zero register: ZERO_REG=1, write r0 = 0xFFFFFFFF and issue r0 → owReadData1 = 0 and owBusy1 = 0 on every cycle. ZERO_REG=0 → r0 reads 0xFFFFFFFF.
- Scoreboard:
  - Issue r9 → owBusy2 = 1 from the next cycle.
  - Writeback r9 on port 1 → owBusy2 = 0 in that cycle and stays 0.
  - Issue r9 together with writeback r9 → busy remains 1.
- Parameter sweep: WIDTH = 16 / DEPTH = 8 and WIDTH = 64 / DEPTH = 64, random dual writes, reads and issues against a reference model for 10k cycles → zero mismatches.
